mul_addtree_pipe: RTL

Parametrised, fully pipelined add-tree multiplier. It is the next generation of the fixed 4-bit two-stage add-tree multiplier: operand width is generic, the tree is registered after every adder level, and a valid/ready handshake with back-pressure is provided. Optional two's-complement mode is available. It sits in the arithmetic datapath wherever a streaming W×W→2W product is needed at one result per clock.

---
 rtl/mul_addtree_pkg.sv | 27 ++
 rtl/mul_addtree_level.sv | 42 ++++
 rtl/mul_addtree_pipe.sv | 96 +++++++++
 3 files changed

// File: rtl/mul_addtree_pkg.sv
// Shared constants and elaboration helpers for the pipelined add-tree multiplier.
package mul_addtree_pkg;

  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Number of registered adder levels and total input-to-output latency.
  function automatic int levels_of(input int w);
    return clog2(w);
  endfunction

  function automatic int lat_of(input int w);
    return clog2(w) + 1;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/mul_addtree_level.sv
// One registered adder level: N_IN operands summed pairwise into N_IN/2 results.
module mul_addtree_level #(
  parameter int N_IN = 2,
  parameter int W    = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic [N_IN-1:0][W-1:0]     in_data,
  input  logic                       in_valid,
  output logic [N_IN/2-1:0][W-1:0]   out_data,
  output logic                       out_valid
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT-1:0][W-1:0] sum_d, sum_q;
  logic                    valid_d, valid_q;

  // Sums wrap at W bits; the final product never needs more.
  always_comb begin
    sum_d   = '0;
    valid_d = in_valid;
    for (int j = 0; j < N_OUT; j++) begin
      sum_d[j] = in_data[2*j] + in_data[2*j+1];
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = sum_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/mul_addtree_pipe.sv
// Streaming WIDTH x WIDTH -> 2*WIDTH add-tree multiplier, registered after every level.
// Define MUL_ADDTREE_SIGNED_EN to add the sgn port and two's-complement mode.
module mul_addtree_pipe
  import mul_addtree_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef MUL_ADDTREE_SIGNED_EN
  input  logic               sgn,
`endif
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int LEVELS = levels_of(WIDTH);
  localparam int W2     = 2 * WIDTH;

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("mul_addtree_pipe: WIDTH must be a power of two in 4..16");
  end

  // Handshake: input transfers on in_valid & in_ready, output on out_valid &
  // out_ready. The whole pipe moves together on en; a stalled output freezes
  // every stage, and in_ready is low for exactly those cycles.
  logic                     en;
  logic [WIDTH-1:0][W2-1:0] pp_d, pp_q;
  logic                     pp_valid_d, pp_valid_q;
  logic [W2-1:0]            x_ext;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    x_ext = {{WIDTH{1'b0}}, x};
`ifdef MUL_ADDTREE_SIGNED_EN
    if (sgn) x_ext = {{WIDTH{x[WIDTH-1]}}, x};
`endif
    pp_valid_d = in_valid;
    pp_d       = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_valid && y[i]) pp_d[i] = x_ext << i;
    end
`ifdef MUL_ADDTREE_SIGNED_EN
    // The multiplier's top bit carries weight -2^(W-1) in signed mode.
    if (in_valid && sgn && y[WIDTH-1]) pp_d[WIDTH-1] = -pp_d[WIDTH-1];
`endif
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pp_q       <= '0;
      pp_valid_q <= 1'b0;
    end else if (en) begin
      pp_q       <= pp_d;
      pp_valid_q <= pp_valid_d;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN = WIDTH >> l;
    logic [N_IN/2-1:0][W2-1:0] sum;
    logic                      vld;
    if (l == 0) begin : g_first
      mul_addtree_level #(.N_IN(N_IN), .W(W2)) u_level (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .in_data   (pp_q),
        .in_valid  (pp_valid_q),
        .out_data  (sum),
        .out_valid (vld)
      );
    end else begin : g_next
      mul_addtree_level #(.N_IN(N_IN), .W(W2)) u_level (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .in_data   (g_lvl[l-1].sum),
        .in_valid  (g_lvl[l-1].vld),
        .out_data  (sum),
        .out_valid (vld)
      );
    end
  end

  assign out       = g_lvl[LEVELS-1].sum[0];
  assign out_valid = g_lvl[LEVELS-1].vld;

endmodule
